// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its requester arbiter.
//   - ALU function codes (3 bits)
//   - requester ID width and ID type
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU function codes. Bit 2 selects the inverted-b adder path (SUB / SLT).
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Requester identifier width: two requesters share the ALU.
  localparam int ALU_ID_W = 1;

  typedef logic [2:0]          alu_fun_t;
  typedef logic [ALU_ID_W-1:0] req_id_t;

  localparam req_id_t REQ0_ID = 1'b0;
  localparam req_id_t REQ1_ID = 1'b1;

endpackage

// File: rtl/alu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu
// Purely combinational N-bit ALU.
//   AND / OR : bitwise, c = 0
//   ADD      : y = a + b,          c = carry out
//   SUB      : y = a + ~b + 1,     c = carry out (1 means no borrow)
//   SLT      : y = (signed a < signed b) ? 1 : 0, c = 0
//   other    : y = 0, c = 0
// Ports:
//   a, b  in  N  operands
//   fun   in  3  function code (alu_pkg::ALU_*)
//   y     out N  result
//   c     out 1  carry/flag
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_fun_t     fun,
  output logic [N-1:0] y,
  output logic         c
);

  logic         sub_s;
  logic [N-1:0] b_in_s;
  logic [N:0]   sum_s;
  logic         slt_s;

  // Shared adder: bit 2 of the code inverts b and injects a carry-in of one.
  always_comb begin
    sub_s  = fun[2];
    b_in_s = sub_s ? ~b : b;
    sum_s  = {1'b0, a} + {1'b0, b_in_s} + {{N{1'b0}}, sub_s};
  end

  // Signed less-than: when the signs differ the sign of a decides, otherwise
  // the difference cannot overflow and its sign bit is the answer.
  always_comb begin
    if (a[N-1] != b[N-1]) begin
      slt_s = a[N-1];
    end else begin
      slt_s = sum_s[N-1];
    end
  end

  // Function decode; unused codes return zero with no flag.
  always_comb begin
    y = {N{1'b0}};
    c = 1'b0;
    case (fun)
      ALU_AND: begin
        y = a & b;
        c = 1'b0;
      end
      ALU_OR: begin
        y = a | b;
        c = 1'b0;
      end
      ALU_ADD: begin
        y = sum_s[N-1:0];
        c = sum_s[N];
      end
      ALU_SUB: begin
        y = sum_s[N-1:0];
        c = sum_s[N];
      end
      ALU_SLT: begin
        y = {{(N-1){1'b0}}, slt_s};
        c = 1'b0;
      end
      default: begin
        y = {N{1'b0}};
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational alu between two valid/ready requesters. The winner's
// operation goes through the ALU and its result is registered together with
// the winner's ID on a single response channel with backpressure.
// Throughput one operation per cycle, latency one cycle.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   : ties go to the requester not accepted last
//                              (round robin, 'last' register resets to 1)
//                  undefined : requester 0 always wins ties; no 'last' register
//
// Ports:
//   clk                      in   clock, rising edge
//   rst                      in   asynchronous active-high reset
//   req0_valid / req1_valid  in   requester has an operation
//   req0_ready / req1_ready  out  operation accepted this cycle
//   req0_a, req0_b (req1_*)  in   N-bit operands
//   req0_fun (req1_fun)      in   3-bit ALU function code
//   res_valid                out  result register holds an unconsumed result
//   res_ready                in   consumer takes the result this cycle
//   res_id                   out  requester that issued the result
//   res_y                    out  N-bit ALU result
//   res_c                    out  ALU carry/flag
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [N-1:0]        req0_a,
  input  logic [N-1:0]        req0_b,
  input  logic [2:0]          req0_fun,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [N-1:0]        req1_a,
  input  logic [N-1:0]        req1_b,
  input  logic [2:0]          req1_fun,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ALU_ID_W-1:0] res_id,
  output logic [N-1:0]        res_y,
  output logic                res_c
);

  logic [1:0]   grant_s;
  logic         slot_free_s;
  logic         accept_s;
  req_id_t      win_id_s;
  logic [N-1:0] alu_a_s;
  logic [N-1:0] alu_b_s;
  alu_fun_t     alu_fun_s;
  logic [N-1:0] alu_y_s;
  logic         alu_c_s;

  logic         res_valid_r;
  req_id_t      res_id_r;
  logic [N-1:0] res_y_r;
  logic         res_c_r;

`ifdef ALU_ARB_RR_EN
  req_id_t      last_r;
`endif

  // Grant: a lone requester wins; a tie goes by the configured policy.
  always_comb begin
    grant_s = 2'b00;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      if (last_r == REQ1_ID) begin
        grant_s = 2'b01;
      end else begin
        grant_s = 2'b10;
      end
`else
      grant_s = 2'b01;
`endif
    end else if (req0_valid) begin
      grant_s = 2'b01;
    end else if (req1_valid) begin
      grant_s = 2'b10;
    end else begin
      grant_s = 2'b00;
    end
  end

  // Handshake: the slot is free when empty or being drained this cycle, so a
  // new result may replace the outgoing one without a bubble.
  always_comb begin
    slot_free_s = ~res_valid_r | res_ready;
    req0_ready  = grant_s[0] & slot_free_s & ~rst;
    req1_ready  = grant_s[1] & slot_free_s & ~rst;
    accept_s    = req0_ready | req1_ready;
    win_id_s    = grant_s[1] ? REQ1_ID : REQ0_ID;
  end

  // Operand mux: feed the granted requester into the shared ALU.
  always_comb begin
    if (grant_s[1]) begin
      alu_a_s   = req1_a;
      alu_b_s   = req1_b;
      alu_fun_s = req1_fun;
    end else begin
      alu_a_s   = req0_a;
      alu_b_s   = req0_b;
      alu_fun_s = req0_fun;
    end
  end

  alu #(N) u_alu (
    .a   (alu_a_s),
    .b   (alu_b_s),
    .fun (alu_fun_s),
    .y   (alu_y_s),
    .c   (alu_c_s)
  );

  // Result register: load on acceptance, drop valid when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_id_r    <= REQ0_ID;
      res_y_r     <= {N{1'b0}};
      res_c_r     <= 1'b0;
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_id_r    <= win_id_s;
      res_y_r     <= alu_y_s;
      res_c_r     <= alu_c_s;
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Round-robin history: resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= REQ1_ID;
    end else if (accept_s) begin
      last_r <= win_id_s;
    end
  end
`endif

  // Output drive straight from the result register.
  always_comb begin
    res_valid = res_valid_r;
    res_id    = res_id_r;
    res_y     = res_y_r;
    res_c     = res_c_r;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a cycle model of the arbitration feeds a
// scoreboard queue of expected results; a table of ALU vectors with
// hand-computed answers; directed sequences for round robin, backpressure and
// asynchronous reset. Tie expectations follow ALU_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_fun, req1_fun;
  logic         res_valid, res_ready, res_id, res_c;
  logic [N-1:0] res_y;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fun   (req0_fun),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fun   (req1_fun),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_y      (res_y),
    .res_c      (res_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [N-1:0] y;
    logic         c;
  } res_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   fun;
    logic [N-1:0] y;
    logic         c;
  } vec_t;

  res_t       exp_q[$];
  vec_t       vecs[10];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       m_last;
  logic       m_vld;
  logic [1:0] m_grant = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU returning {carry, result}.
  function automatic logic [N:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] f);
    logic [N:0] s;
    s = '0;
    case (f)
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      ALU_ADD: s = {1'b0, a} + {1'b0, b};
      ALU_SUB: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      ALU_SLT: s[0] = ($signed(a) < $signed(b));
      default: s = '0;
    endcase
    return s;
  endfunction

  // One clock: check ready against the model, advance the model at the edge,
  // then check the result register at the following falling edge.
  task automatic cycle();
    logic [1:0] g;
    logic       slot;
    logic [N:0] r;
    #1;
    slot = !m_vld || res_ready;
    g = 2'b00;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      g = m_last ? 2'b01 : 2'b10;
`else
      g = 2'b01;
`endif
    end else if (req0_valid) begin
      g = 2'b01;
    end else if (req1_valid) begin
      g = 2'b10;
    end
    if (!slot || rst) g = 2'b00;
    chk("ready", {req1_ready, req0_ready}, g);
    m_grant = g;
    @(posedge clk);
    if (!rst) begin
      if (m_vld && res_ready) begin
        void'(exp_q.pop_front());
        m_vld = 1'b0;
      end
      if (g != 2'b00) begin
        r = g[1] ? ref_alu(req1_a, req1_b, req1_fun) : ref_alu(req0_a, req0_b, req0_fun);
        exp_q.push_back(res_t'({g[1], r[N-1:0], r[N]}));
        m_vld  = 1'b1;
        m_last = g[1];
      end
    end
    @(negedge clk);
    chk("res_valid", res_valid, m_vld);
    if (m_vld && exp_q.size() > 0) begin
      chk("res_id", res_id, exp_q[0].id);
      chk("res_y",  res_y,  exp_q[0].y);
      chk("res_c",  res_c,  exp_q[0].c);
    end
  endtask

  task automatic model_reset();
    m_vld   = 1'b0;
    m_last  = 1'b1;
    m_grant = 2'b00;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_ids[4];

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, ALU_ADD, 32'h0000_0008, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0003, ALU_SUB, 32'h0000_0002, 1'b1};
    vecs[3] = '{32'h0000_0003, 32'h0000_0005, ALU_SUB, 32'hFFFF_FFFE, 1'b0};
    vecs[4] = '{32'hF0F0_1234, 32'h0FF0_FF00, ALU_AND, 32'h00F0_1200, 1'b0};
    vecs[5] = '{32'h1234_0000, 32'h0000_5678, ALU_OR,  32'h1234_5678, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT, 32'h0000_0001, 1'b0};
    vecs[7] = '{32'h0000_0001, 32'hFFFF_FFFF, ALU_SLT, 32'h0000_0000, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'h0000_0001, 1'b0};
    vecs[9] = '{32'hDEAD_BEEF, 32'h0000_0001, 3'b011,  32'h0000_0000, 1'b0};

    // Reset values with both requesters asking.
    rst = 1'b1;
    model_reset();
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;  req0_fun = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_fun = ALU_ADD;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_res_y", res_y, 32'h0);
    chk("rst_res_c", res_c, 1'b0);
    rst = 1'b0;
    cycle();
    chk("first_tie_id", res_id, 1'b0);
    chk("first_tie_y", res_y, 32'd3);

    // Table of single-requester operations.
    req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      req0_a = vecs[i].a; req0_b = vecs[i].b; req0_fun = vecs[i].fun;
      cycle();
      chk($sformatf("vec%0d_y", i), res_y, vecs[i].y);
      chk($sformatf("vec%0d_c", i), res_c, vecs[i].c);
      chk($sformatf("vec%0d_id", i), res_id, 1'b0);
    end

    // Tie handling with both requesters continuously valid.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_fun = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_fun = ALU_SUB;
    res_ready = 1'b1;
    do_reset();
`ifdef ALU_ARB_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("tie%0d_id", i), res_id, exp_ids[i]);
      chk($sformatf("tie%0d_y", i), res_y, exp_ids[i] ? 32'd99 : 32'd101);
    end

    // Backpressure: load one result, stall five cycles, then release.
    req1_valid = 1'b0;
    req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F; req0_fun = ALU_AND;
    res_ready = 1'b1;
    cycle();
    chk("bp_load_y", res_y, 32'h0F0F_0000);
    res_ready = 1'b0;
    req0_a = 32'd7; req0_b = 32'd8; req0_fun = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_fun = ALU_OR;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_y", res_y, 32'h0F0F_0000);
      chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
    end
    res_ready = 1'b1;
    cycle();
`ifdef ALU_ARB_RR_EN
    chk("bp_release_id", res_id, 1'b1);
    chk("bp_release_y", res_y, 32'd3);
`else
    chk("bp_release_id", res_id, 1'b0);
    chk("bp_release_y", res_y, 32'd15);
`endif

    // Asynchronous reset while a result is pending.
    res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle();
    chk("arst_pending", res_valid, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_valid_now", res_valid, 1'b0);
    chk("arst_ready_now", {req1_ready, req0_ready}, 2'b00);
    res_ready = 1'b1;
    @(negedge clk);
    chk("arst_no_accept", res_valid, 1'b0);
    #2;
    rst = 1'b0;
    cycle();
    chk("arst_restart_id", res_id, 1'b0);

    // Random soak; operands held while a request is waiting.
    for (int i = 0; i < 500; i++) begin
      if (!(req0_valid && !m_grant[0])) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_a     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        req0_b     = $urandom;
        req0_fun   = 3'($urandom_range(0, 7));
      end
      if (!(req1_valid && !m_grant[1])) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_a     = $urandom;
        req1_b     = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
        req1_fun   = 3'($urandom_range(0, 7));
      end
      res_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Drain.
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two independent requesters, such as the execute stage and an address/branch helper in the multi-cycle core. Each requester uses a valid/ready channel. The block arbitrates between them, registers the ALU result with the winner's ID, and returns it on one shared response channel with backpressure. Sustained throughput is one operation per cycle; latency is one cycle.

## Interface
Parameters:
- `N`, 32, operand/result width; passed to the internal `alu #(N)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation is accepted this cycle.
- `req0_a`, `req0_b`  in  N  requester 0 operands.
- `req0_fun`  in  3  requester 0 ALU function code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_fun`: same as requester 0, for requester 1.
- `res_valid`  out  1  the result register holds an unconsumed result.
- `res_ready`  in  1  the consumer takes the result this cycle.
- `res_id`  out  1  requester that issued the result.
- `res_y`  out  N  ALU result.
- `res_c`  out  1  ALU carry/flag output.

## Operation
- Handshake: a transfer happens when `valid && ready` are both high on a rising edge.
- A requester must hold its operands and function code stable while `valid` is high and `ready` is low.
- `slot_free = !res_valid || res_ready`. This combinational path lets a new result replace the one being drained in the same cycle.
- Grant is combinational:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not named by `last` wins. `last` is a 1-bit register holding the ID of the most recent accepted requester.
- `reqX_ready = grant[X] && slot_free`. At most one `ready` is high in any cycle.
- `ready` may depend on `valid`; a requester must not gate its `valid` on `ready`.
- The ALU mux selects the granted requester's `a`, `b` and `fun`.
- On an accepted transfer, these load in the same edge:
  - `res_y` and `res_c` from the ALU outputs;
  - `res_id` and `last` from the winner's ID;
  - `res_valid` set to 1.
- On `res_valid && res_ready` with no new acceptance, `res_valid` clears. `res_y`, `res_c` and `res_id` hold their last values.
- Width rules: `res_y` is exactly N bits with no extension. `res_c` is passed through from the ALU unchanged.
- Stall: while `res_valid && !res_ready`, both `ready` outputs are 0. The stored result stays unchanged until consumed.

## Timing
- Reset values: `res_valid`=0, `res_id`=0, `res_y`=0, `res_c`=0, `last`=1, so requester 0 wins the first tie.
- Both `ready` outputs are 0 while `rst` is high.
- Latency: accepted at edge k, the result is visible with `res_valid`=1 after edge k.
- Back-to-back operation with `res_ready` held at 1 gives one result per cycle. The IDs alternate when both requesters stay valid.
- Reset asserted mid-operation: the pending result is dropped immediately, no acceptance occurs while reset is high, and arbitration restarts from the reset state.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin tie-break using `last`, as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins ties. The `last` register is omitted; starvation of requester 1 is accepted.

## Structure
- Shared package `alu_pkg` holds:
  - function-code constants: `ALU_AND`=3'b000, `ALU_OR`=3'b001, `ALU_ADD`=3'b010, `ALU_SUB`=3'b110, `ALU_SLT`=3'b111;
  - the requester ID width constant (1).
- One sub-module: the existing `alu`, instantiated once as `alu #(N) u_alu`. The grant logic stays inline.

## Test plan
1. **Reset values.** Hold `rst`=1 with both requesters valid → `res_valid`=0, both `ready`=0. Release `rst` → the first acceptance is requester 0.
2. **Single add with carry.** req0 `ALU_ADD`, a=32'h0000_0005, b=32'h0000_0003, `res_ready`=1 → next cycle `res_valid`=1, `res_id`=0, `res_y`=32'h0000_0008. Repeat with a=32'hFFFF_FFFF, b=32'h1 → `res_y`=0, `res_c`=1.
3. **Round-robin.** Both requesters continuously valid, `res_ready`=1 → `res_id` sequence 0,1,0,1 over 4 cycles with correct per-requester results. Without `ALU_ARB_RR_EN` → sequence 0,0,0,0.
4. **Backpressure.** `res_ready`=0 with a result held → both `ready`=0 and `res_y` unchanged for 5 cycles. Raise `res_ready` → the next operation is accepted in that same cycle, no bubble.
5. **Reset mid-flight.** Assert `rst` asynchronously between edges while `res_valid`=1 → `res_valid` drops immediately without waiting for a clock edge, and no result is lost to a later acceptance.
6. **Random soak.** 500 cycles of `$random` operands, function codes and valid/ready patterns → every accepted request produces exactly one result with the matching ID and reference-model value. No request is dropped; operands are stable while stalled.
